// File: rtl/power_up_mgr_if.sv
// Bus between power_up_mgr and its neighbours: map-write port, player position and spawn
// threshold in, item pool and player stats out.
interface power_up_mgr_if #(
   parameter int unsigned NUM_SLOTS     = 4,
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned TYPE_W        = 2,
   parameter int unsigned MAP_MEM_WIDTH = 2
);
   logic                            tick;
   logic                            we_in;
   logic [ADDR_WIDTH-1:0]           write_addr_in;
   logic [MAP_MEM_WIDTH-1:0]        write_data_in;
   logic [10:0]                     player_x;
   logic [9:0]                      player_y;
   logic [31:0]                     probability;
   logic [NUM_SLOTS*ADDR_WIDTH-1:0] item_addr;
   logic [NUM_SLOTS*TYPE_W-1:0]     item_type;
   logic [NUM_SLOTS-1:0]            item_active;
   logic                            pickup_pulse;
   logic [TYPE_W-1:0]               pickup_type;
   logic [3:0]                      max_bombs;
   logic [5:0]                      player_speed;
   logic [3:0]                      bomb_range;

   modport master (
      output tick, we_in, write_addr_in, write_data_in, player_x, player_y, probability,
      input  item_addr, item_type, item_active, pickup_pulse, pickup_type, max_bombs,
             player_speed, bomb_range
   );

   modport slave (
      input  tick, we_in, write_addr_in, write_data_in, player_x, player_y, probability,
      output item_addr, item_type, item_active, pickup_pulse, pickup_type, max_bombs,
             player_speed, bomb_range
   );
endinterface

// File: rtl/power_up_mgr.sv
// Power-up manager: LFSR-gated item spawning into freed map cells, pickup detection and stats.
// Define POWER_UP_EXPIRE_EN to give each item a tick-based lifetime.
module power_up_mgr #(
   parameter int unsigned NUM_ROW       = 11,
   parameter int unsigned NUM_COL       = 19,
   parameter int unsigned TILE_PX       = 64,
   parameter int unsigned MAP_MEM_WIDTH = 2,
   parameter int unsigned SPRITE_W      = 32,
   parameter int unsigned SPRITE_H      = 48,
   parameter int unsigned NUM_SLOTS     = 4,
   parameter int unsigned NUM_TYPES     = 3,
   parameter int unsigned ITEM_TIME     = 6,
   parameter int unsigned SPEED_STEP    = 4,
   parameter int unsigned SPEED_MAX     = 28,
   parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
   input logic           clk,
   input logic           rst,
   power_up_mgr_if.slave bus
);
   localparam int unsigned TILE_SHIFT = $clog2(TILE_PX);
   localparam int unsigned DEPTH      = NUM_ROW * NUM_COL;
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
   localparam int unsigned TYPE_W     = $clog2(NUM_TYPES);
   localparam int unsigned LIFE_W     = $clog2(ITEM_TIME + 1);

   logic [31:0]           lfsr_q, lfsr_d;
   logic [NUM_SLOTS-1:0]  active_q, active_d;
   logic [ADDR_WIDTH-1:0] addr_q [NUM_SLOTS];
   logic [ADDR_WIDTH-1:0] addr_d [NUM_SLOTS];
   logic [TYPE_W-1:0]     type_q [NUM_SLOTS];
   logic [TYPE_W-1:0]     type_d [NUM_SLOTS];
   logic [TYPE_W-1:0]     rr_q, rr_d;
   logic                  pulse_q, pulse_d;
   logic [TYPE_W-1:0]     ptype_q, ptype_d;
   logic [3:0]            bombs_q, bombs_d;
   logic [5:0]            speed_q, speed_d;
   logic [3:0]            range_q, range_d;

`ifdef POWER_UP_EXPIRE_EN
   logic [LIFE_W-1:0]     life_q [NUM_SLOTS];
   logic [LIFE_W-1:0]     life_d [NUM_SLOTS];
`else
   logic                  unused_tick;
   assign unused_tick = bus.tick;
`endif

   // Player tile is taken from the sprite centre, not its top-left corner.
   logic [11:0]           center_x;
   logic [10:0]           center_y;
   logic [ADDR_WIDTH-1:0] player_addr;

   assign center_x    = {1'b0, bus.player_x} + 12'(SPRITE_W / 2);
   assign center_y    = {1'b0, bus.player_y} + 11'(SPRITE_H / 2);
   assign player_addr = ADDR_WIDTH'(center_y >> TILE_SHIFT) * ADDR_WIDTH'(NUM_COL)
                      + ADDR_WIDTH'(center_x >> TILE_SHIFT);

   logic [NUM_SLOTS-1:0] pick_oh, free_oh, dup;
   logic                 found_pick, found_free, spawn;
   logic [TYPE_W-1:0]    pick_type;

   always_comb begin
      pick_oh    = '0;
      free_oh    = '0;
      dup        = '0;
      found_pick = 1'b0;
      found_free = 1'b0;
      pick_type  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         dup[i] = active_q[i] && (addr_q[i] == bus.write_addr_in);
         if (active_q[i] && (addr_q[i] == player_addr) && !found_pick) begin
            pick_oh[i] = 1'b1;
            pick_type  = type_q[i];
            found_pick = 1'b1;
         end
         if (!active_q[i] && !found_free) begin
            free_oh[i] = 1'b1;
            found_free = 1'b1;
         end
      end
   end

   // Free slots come from registered state, so a slot cleared this cycle is not reused yet.
   assign spawn = bus.we_in && (bus.write_data_in == '0) && (lfsr_q < bus.probability)
                && !(|dup) && found_free;

   assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

   always_comb begin
      active_d = active_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         addr_d[i] = addr_q[i];
         type_d[i] = type_q[i];
`ifdef POWER_UP_EXPIRE_EN
         life_d[i] = life_q[i];
         if (bus.tick && active_q[i]) begin
            life_d[i] = life_q[i] - LIFE_W'(1);
            if (life_q[i] <= LIFE_W'(1)) active_d[i] = 1'b0;
         end
`endif
         if (pick_oh[i]) active_d[i] = 1'b0;
         if (spawn && free_oh[i]) begin
            active_d[i] = 1'b1;
            addr_d[i]   = bus.write_addr_in;
            type_d[i]   = rr_q;
`ifdef POWER_UP_EXPIRE_EN
            life_d[i]   = LIFE_W'(ITEM_TIME);
`endif
         end
      end
   end

   always_comb begin
      speed_d = speed_q;
      bombs_d = bombs_q;
      range_d = range_q;
      ptype_d = ptype_q;
      pulse_d = found_pick;
      rr_d    = rr_q;
      if (found_pick) begin
         ptype_d = pick_type;
         case (pick_type)
            TYPE_W'(0): begin
               if ({1'b0, speed_q} + 7'(SPEED_STEP) <= 7'(SPEED_MAX)) begin
                  speed_d = speed_q + 6'(SPEED_STEP);
               end
            end
            TYPE_W'(1): if (bombs_q < 4'd9) bombs_d = bombs_q + 4'd1;
            TYPE_W'(2): if (range_q < 4'd9) range_d = range_q + 4'd1;
            default: ;
         endcase
      end
      if (spawn) rr_d = (rr_q == TYPE_W'(NUM_TYPES - 1)) ? '0 : rr_q + TYPE_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q   <= LFSR_SEED;
         active_q <= '0;
         rr_q     <= '0;
         pulse_q  <= 1'b0;
         ptype_q  <= '0;
         bombs_q  <= 4'd1;
         speed_q  <= 6'd4;
         range_q  <= 4'd1;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            addr_q[i] <= '0;
            type_q[i] <= '0;
         end
      end else begin
         lfsr_q   <= lfsr_d;
         active_q <= active_d;
         rr_q     <= rr_d;
         pulse_q  <= pulse_d;
         ptype_q  <= ptype_d;
         bombs_q  <= bombs_d;
         speed_q  <= speed_d;
         range_q  <= range_d;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            addr_q[i] <= addr_d[i];
            type_q[i] <= type_d[i];
         end
      end
   end

`ifdef POWER_UP_EXPIRE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) life_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) life_q[i] <= life_d[i];
      end
   end
`endif

   logic [NUM_SLOTS*ADDR_WIDTH-1:0] addr_flat;
   logic [NUM_SLOTS*TYPE_W-1:0]     type_flat;

   always_comb begin
      addr_flat = '0;
      type_flat = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         addr_flat[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[i];
         type_flat[i*TYPE_W +: TYPE_W]         = type_q[i];
      end
   end

   assign bus.item_addr    = addr_flat;
   assign bus.item_type    = type_flat;
   assign bus.item_active  = active_q;
   assign bus.pickup_pulse = pulse_q;
   assign bus.pickup_type  = ptype_q;
   assign bus.max_bombs    = bombs_q;
   assign bus.player_speed = speed_q;
   assign bus.bomb_range   = range_q;
endmodule

// File: tb/tb_power_up_mgr.sv
// Directed testbench for power_up_mgr: spawn, pool limits, pickups, stat caps, expiry.
module tb_power_up_mgr;
   localparam int AW = 8;
   localparam int TW = 2;
   localparam int NS = 4;
   localparam int NC = 19;
   localparam int PARK = 208;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   int spd_tab [3][9];

   power_up_mgr_if #(.NUM_SLOTS(NS), .ADDR_WIDTH(AW), .TYPE_W(TW), .MAP_MEM_WIDTH(2)) bus ();

   power_up_mgr dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] s_addr(input int i);
      return bus.item_addr[i*AW +: AW];
   endfunction

   function automatic logic [TW-1:0] s_type(input int i);
      return bus.item_type[i*TW +: TW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cell(input int a, input logic [1:0] d);
      bus.we_in         = 1'b1;
      bus.write_addr_in = AW'(a);
      bus.write_data_in = d;
      step();
      bus.we_in         = 1'b0;
   endtask

   task automatic place(input int a);
      bus.player_x = 11'((a % NC) * 64 + 16);
      bus.player_y = 10'((a / NC) * 64 + 8);
   endtask

   task automatic do_reset();
      bus.tick  = 1'b0;
      bus.we_in = 1'b0;
      place(PARK);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (bus.item_active !== 4'b0000) begin fails++;
         $display("FAIL reset_active got %b want 0000", bus.item_active); end
      tests++; if (bus.item_addr !== 32'h0 || bus.item_type !== 8'h0) begin fails++;
         $display("FAIL reset_slots got %h/%h want 0/0", bus.item_addr, bus.item_type); end
      tests++; if (bus.pickup_pulse !== 1'b0 || bus.pickup_type !== 2'd0) begin fails++;
         $display("FAIL reset_pickup got %b/%0d want 0/0", bus.pickup_pulse, bus.pickup_type); end
      tests++; if (bus.max_bombs !== 4'd1 || bus.player_speed !== 6'd4 || bus.bomb_range !== 4'd1)
         begin fails++; $display("FAIL reset_stats got %0d/%0d/%0d want 1/4/1",
            bus.max_bombs, bus.player_speed, bus.bomb_range); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_spawn();
      do_reset();
      bus.probability = 32'hFFFF_FFFF;
      write_cell(25, 2'd0);
      tests++; if (bus.item_active !== 4'b0001) begin fails++;
         $display("FAIL spawn_active got %b want 0001", bus.item_active); end
      tests++; if (s_addr(0) !== 8'd25 || s_type(0) !== 2'd0) begin fails++;
         $display("FAIL spawn_slot0 got %0d/%0d want 25/0", s_addr(0), s_type(0)); end
      write_cell(25, 2'd0);
      tests++; if (bus.item_active !== 4'b0001) begin fails++;
         $display("FAIL spawn_dup got %b want 0001", bus.item_active); end
      write_cell(70, 2'd1);
      tests++; if (bus.item_active !== 4'b0001) begin fails++;
         $display("FAIL spawn_nonfree got %b want 0001", bus.item_active); end
      write_cell(30, 2'd0);
      write_cell(40, 2'd0);
      write_cell(50, 2'd0);
      tests++; if (bus.item_active !== 4'b1111) begin fails++;
         $display("FAIL fill_active got %b want 1111", bus.item_active); end
      tests++; if (bus.item_type !== 8'b00_10_01_00) begin fails++;
         $display("FAIL fill_types got %b want 00100100", bus.item_type); end
      tests++; if (bus.item_addr !== {8'd50, 8'd40, 8'd30, 8'd25}) begin fails++;
         $display("FAIL fill_addrs got %h want 32281e19", bus.item_addr); end
      write_cell(60, 2'd0);
      tests++; if (bus.item_active !== 4'b1111 || bus.item_addr !== {8'd50, 8'd40, 8'd30, 8'd25})
         begin fails++; $display("FAIL full_drop got %b/%h want 1111/32281e19",
            bus.item_active, bus.item_addr); end
   endtask

   task automatic test_prob_zero();
      do_reset();
      bus.probability = 32'h0;
      for (int i = 1; i <= 100; i++) begin
         write_cell(i, 2'd0);
         tests++; if (bus.item_active !== 4'b0000) begin fails++;
            $display("FAIL prob0_spawn addr %0d got %b want 0000", i, bus.item_active); end
      end
   endtask

   // Nine rounds of spawning types 0,1,2 at cells 30..32 and collecting all three.
   task automatic test_stats();
      int got;
      do_reset();
      bus.probability = 32'hFFFF_FFFF;
      for (int k = 0; k < 9; k++) begin
         write_cell(30, 2'd0);
         write_cell(31, 2'd0);
         write_cell(32, 2'd0);
         tests++; if (bus.item_active !== 4'b0111 || bus.item_type !== 8'b00_10_01_00) begin
            fails++; $display("FAIL round%0d_spawn got %b/%b want 0111/00100100",
               k, bus.item_active, bus.item_type); end
         for (int t = 0; t < 3; t++) begin
            place(30 + t);
            step();
            got = (t == 0) ? int'(bus.player_speed) : (t == 1) ? int'(bus.max_bombs)
                                                              : int'(bus.bomb_range);
            tests++; if (bus.pickup_pulse !== 1'b1 || bus.pickup_type !== TW'(t)) begin fails++;
               $display("FAIL round%0d_pick%0d pulse/type got %b/%0d want 1/%0d",
                  k, t, bus.pickup_pulse, bus.pickup_type, t); end
            tests++; if (got != spd_tab[t][k]) begin fails++;
               $display("FAIL round%0d_stat%0d got %0d want %0d", k, t, got, spd_tab[t][k]); end
            tests++; if (bus.item_active[t] !== 1'b0) begin fails++;
               $display("FAIL round%0d_clear%0d got %b want 0", k, t, bus.item_active[t]); end
            step();
            tests++; if (bus.pickup_pulse !== 1'b0) begin fails++;
               $display("FAIL round%0d_pulse_len%0d got %b want 0", k, t, bus.pickup_pulse); end
            place(PARK);
         end
      end
   endtask

   task automatic test_concurrent();
      do_reset();
      bus.probability = 32'hFFFF_FFFF;
      write_cell(30, 2'd0);
      place(30);
      write_cell(40, 2'd0);
      tests++; if (bus.pickup_pulse !== 1'b1 || bus.player_speed !== 6'd8) begin fails++;
         $display("FAIL conc_pick got %b/%0d want 1/8", bus.pickup_pulse, bus.player_speed); end
      tests++; if (bus.item_active !== 4'b0010 || s_addr(1) !== 8'd40 || s_type(1) !== 2'd1)
         begin fails++; $display("FAIL conc_spawn got %b/%0d/%0d want 0010/40/1",
            bus.item_active, s_addr(1), s_type(1)); end
      place(PARK);
      #3;
      rst = 1'b1;
      #1;
      tests++; if (bus.item_active !== 4'b0000 || bus.player_speed !== 6'd4) begin fails++;
         $display("FAIL mid_reset got %b/%0d want 0000/4", bus.item_active, bus.player_speed); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_expiry();
      do_reset();
      bus.probability = 32'hFFFF_FFFF;
      write_cell(50, 2'd0);
`ifdef POWER_UP_EXPIRE_EN
      for (int n = 1; n <= 6; n++) begin
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         tests++; if (bus.item_active[0] !== (n < 6)) begin fails++;
            $display("FAIL expire_tick%0d got %b want %b", n, bus.item_active[0], n < 6); end
         step();
      end
      tests++; if (bus.pickup_pulse !== 1'b0 || bus.player_speed !== 6'd4) begin fails++;
         $display("FAIL expire_nostat got %b/%0d want 0/4", bus.pickup_pulse, bus.player_speed); end
      write_cell(50, 2'd0);
      for (int n = 1; n <= 5; n++) begin
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         step();
      end
      place(50);
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      tests++; if (bus.pickup_pulse !== 1'b1 || bus.max_bombs !== 4'd2 || bus.item_active[0] !== 1'b0)
         begin fails++; $display("FAIL expire_vs_pick got %b/%0d/%b want 1/2/0",
            bus.pickup_pulse, bus.max_bombs, bus.item_active[0]); end
      place(PARK);
`else
      for (int n = 1; n <= 20; n++) begin
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         step();
      end
      tests++; if (bus.item_active !== 4'b0001 || s_addr(0) !== 8'd50) begin fails++;
         $display("FAIL persist got %b/%0d want 0001/50", bus.item_active, s_addr(0)); end
`endif
   endtask

   initial begin
      spd_tab[0] = '{8, 12, 16, 20, 24, 28, 28, 28, 28};
      spd_tab[1] = '{2, 3, 4, 5, 6, 7, 8, 9, 9};
      spd_tab[2] = '{2, 3, 4, 5, 6, 7, 8, 9, 9};
      rst               = 1'b1;
      bus.tick          = 1'b0;
      bus.we_in         = 1'b0;
      bus.write_addr_in = '0;
      bus.write_data_in = '0;
      bus.probability   = 32'h0;
      place(PARK);
      test_reset();
      test_spawn();
      test_prob_zero();
      test_stats();
      test_concurrent();
      test_expiry();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/power_up_mgr.md
Name: power_up_mgr

Overview:
Parametrised successor of the three-slot power-up logic. Spawns items into freed map blocks using an internal LFSR compared against a probability threshold. Items go into a pool of NUM_SLOTS generic slots, with the type assigned round-robin over NUM_TYPES. The block detects when the player is on an item, retires the item, and updates the player stat registers. Sits between the free-block writer (map RAM write port) and drawcon/player/bomb logic.

Parameters:
NUM_ROW, 11, map rows
NUM_COL, 19, map columns
TILE_PX, 64, tile size in pixels (power of 2); TILE_SHIFT=$clog2(TILE_PX)
MAP_MEM_WIDTH, 2, map cell width
SPRITE_W, 32, player sprite width px
SPRITE_H, 48, player sprite height px
NUM_SLOTS, 4, concurrent item slots (1..8)
NUM_TYPES, 3, item types (3..4); 0=speed, 1=extra bomb, 2=range, 3=no-stat (score only)
ITEM_TIME, 6, item lifetime in ticks
SPEED_STEP, 4, speed increment per pickup
SPEED_MAX, 28, speed cap
LFSR_SEED, 32'hACE1_2468, nonzero LFSR reset value
Derived: DEPTH=NUM_ROW*NUM_COL, ADDR_WIDTH=$clog2(DEPTH), TYPE_W=$clog2(NUM_TYPES)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  lifetime time-base strobe, one clk wide
we_in  in  1  map write strobe from free-block logic
write_addr_in  in  ADDR_WIDTH  cell being written
write_data_in  in  MAP_MEM_WIDTH  new cell value; 0 = freed block
player_x  in  11  map player x px
player_y  in  10  map player y px
probability  in  32  spawn threshold; spawn when lfsr < probability
item_addr  out  NUM_SLOTS*ADDR_WIDTH  per-slot cell address, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH]
item_type  out  NUM_SLOTS*TYPE_W  per-slot type
item_active  out  NUM_SLOTS  per-slot valid
pickup_pulse  out  1  one-cycle strobe on pickup
pickup_type  out  TYPE_W  type of the last pickup (held)
max_bombs  out  4  bomb allowance
player_speed  out  6  speed
bomb_range  out  4  explosion length

Behaviour:
- Reset (async): all item_active=0, item_addr=0, item_type=0, lifetimes=0, rr type pointer=0, lfsr=LFSR_SEED, pickup_pulse=0, pickup_type=0, max_bombs=1, player_speed=4, bomb_range=1.
- LFSR: 32-bit Galois, taps 32,22,2,1. Advances every clk.
- Spawn condition: we_in & write_data_in==0 & lfsr<probability & no active slot already holding write_addr_in & a free slot exists. Allocate to the lowest-index slot with item_active=0.
- Spawn latency: slot registers are valid 1 cycle after we_in. On spawn: type=rr pointer, lifetime=ITEM_TIME. The rr pointer advances only on a successful spawn and wraps NUM_TYPES-1 to 0.
- Pool full or failed probability: request dropped silently; pointer unchanged.
- Player tile: col=(player_x+SPRITE_W/2)>>TILE_SHIFT, row=(player_y+SPRITE_H/2)>>TILE_SHIFT, addr=row*NUM_COL+col. Computed combinationally.
- Pickup: the lowest-index active slot with item_addr==player addr is selected. Next edge: slot cleared, pickup_pulse=1 for one cycle, pickup_type updated, stat updated.
- At most one pickup per cycle. A second matching slot is taken the following cycle.
- Stat updates:
  - type0: player_speed+=SPEED_STEP if player_speed+SPEED_STEP<=SPEED_MAX, else unchanged.
  - type1: max_bombs+1 if <9.
  - type2: bomb_range+1 if <9.
  - type3: pulse only.
- Lifetime: on tick, each active slot decrements. A slot reaching 0 clears item_active on that same edge. No pulse, no stat change.
- Simultaneous events on the same slot: pickup wins over expiry (stat applied). A slot freed this cycle is not reallocatable until the next cycle, because free status is taken from registered item_active.
- Spawn and pickup in the same cycle on different slots: both occur.
- Reset mid-operation clears the pool and stats immediately.

Optional Feature:
POWER_UP_EXPIRE_EN:
- Defined: lifetime counters and tick-based expiry as above.
- Undefined: no lifetime counters; items persist until picked up; tick is ignored.

Test Plan:
- Reset, then probability=32'hFFFF_FFFF, we_in with write_data_in=0 at addr 25 -> slot0 active, addr 25, type 0 one cycle later; rr pointer=1.
- Five spawns at distinct addrs with NUM_SLOTS=4 -> slots 0..3 filled with types 0,1,2,0; fifth dropped; duplicate addr 25 ignored.
- probability=0 -> no spawn for 100 we_in pulses.
- Player centred on the type1 item cell -> one pickup_pulse, max_bombs 1->2, slot cleared. Repeat to 9 -> max_bombs stays 9.
- Eight type0 pickups -> speed 4,8,...,28, then holds at 28.
- With POWER_UP_EXPIRE_EN: spawn, 6 ticks -> item_active falls on the 6th tick. Pickup coincident with the 6th tick -> stat applied. Without the macro: 20 ticks, item still active.
